// File: rtl/moore_110_pkg.sv
// Shared types and state codes for the "110" Moore detector.
// All four 2-bit codes are legal states; no unused encodings.
package moore_110_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'b00;
  localparam state_t S_1    = 2'b01;
  localparam state_t S_11   = 2'b10;
  localparam state_t S_110  = 2'b11;

  function automatic logic is_hit(
    input state_t s
  );
    return (s == S_110);
  endfunction

endpackage

// File: rtl/moore_110_overlap.sv
// Moore serial detector for "110" with overlap; z high in S_110.
// Ports: clk, rst (async high), x (serial in), z (detect flag).
module moore_110_overlap
  import moore_110_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic z
);

  state_t state;
  state_t state_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // A run of 1s parks in S_11; the trailing 0
  // of a hit cannot start a new match.
  always_comb begin
    state_nx = S_IDLE;
    unique case (state)
      S_IDLE: state_nx = x ? S_1  : S_IDLE;
      S_1:    state_nx = x ? S_11 : S_IDLE;
      S_11:   state_nx = x ? S_11 : S_110;
      S_110:  state_nx = x ? S_1  : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Decoded from the register only: no x-to-z path.
  always_comb begin
    z = is_hit(state);
  end

endmodule

// File: tb/tb_moore_110_overlap.sv
// Directed self-checking bench for moore_110_overlap.
// Drives x on falling edges, checks z 1ns after rising edges.
module tb_moore_110_overlap;

  logic clk;
  logic rst;
  logic x;
  logic z;

  int total;
  int passed;
  int failed;

  moore_110_overlap dut (
    .clk (clk),
    .rst (rst),
    .x   (x),
    .z   (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string tag,
    input logic  exp
  );
    total++;
    assert (z === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: z=%b expected=%b", tag, z, exp);
    end
  endtask

  task automatic step(
    input string tag,
    input logic  b,
    input logic  exp
  );
    @(negedge clk);
    x = b;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    failed = 0;
    rst = 1'b1;
    x   = 1'b1;
    #1;
    check("rst_init", 1'b0);
    @(posedge clk);
    #1;
    check("rst_hold", 1'b0);
    @(negedge clk);
    rst = 1'b0;

    step("basic1", 1'b1, 1'b0);
    step("basic2", 1'b1, 1'b0);
    step("basic3", 1'b0, 1'b1);
    step("basic4", 1'b0, 1'b0);

    step("long1",  1'b0, 1'b0);
    step("long2",  1'b0, 1'b0);
    step("long3",  1'b1, 1'b0);
    step("long4",  1'b1, 1'b0);
    step("long5",  1'b1, 1'b0);
    step("long6",  1'b0, 1'b1);
    step("long7",  1'b1, 1'b0);
    step("long8",  1'b1, 1'b0);
    step("long9",  1'b0, 1'b1);
    step("long10", 1'b0, 1'b0);

    step("ovl1", 1'b1, 1'b0);
    step("ovl2", 1'b1, 1'b0);
    step("ovl3", 1'b0, 1'b1);
    step("ovl4", 1'b1, 1'b0);
    step("ovl5", 1'b1, 1'b0);
    step("ovl6", 1'b0, 1'b1);

    // Async reset while z is high, no clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", 1'b0);
    @(negedge clk);
    rst = 1'b0;

    step("nm1", 1'b1, 1'b0);
    step("nm2", 1'b0, 1'b0);
    step("nm3", 1'b1, 1'b0);
    step("nm4", 1'b0, 1'b0);
    step("nm5", 1'b0, 1'b0);
    step("nm6", 1'b1, 1'b0);

    step("mid1", 1'b1, 1'b0);
    step("mid2", 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    x   = 1'b1;
    #1;
    check("mid_rst", 1'b0);
    @(posedge clk);
    #1;
    check("mid_hold", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step("mid3", 1'b0, 1'b0);
    step("mid4", 1'b1, 1'b0);
    step("mid5", 1'b1, 1'b0);
    step("mid6", 1'b0, 1'b1);
    step("mid7", 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
